divisor_ctrl: RTL and testbench
===============================

# divisor_ctrl

Sequencing controller for the keypad-driven divider. It turns decoded key events into two W-bit hex operands and launches the divider with a single-cycle start pulse. It then waits for completion, latches quotient and remainder, and drives the value and mode shown on the 7-segment display. It sits between the keypad decoder and the divider/display mux inside the divider top level.

## Interface

Parameters:
- W, 8, operand/result width in bits; multiple of 4. NDIG = W/4 hex digits per operand.
- TIMEOUT, 1024, maximum cycles spent in WAIT when the timeout feature is compiled in.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- key_valid  in  1  one-cycle pulse: hex digit key pressed
- key_code  in  4  digit value 0x0–0xF, valid with key_valid
- key_enter  in  1  one-cycle pulse: confirm current operand
- key_clear  in  1  one-cycle pulse: abort and restart entry
- div_start  out  1  one-cycle start pulse to divider
- div_a  out  W  dividend to divider
- div_b  out  W  divisor to divider
- div_done  in  1  divider completion pulse
- div_quot  in  W  quotient, valid with div_done
- div_rem  in  W  remainder, valid with div_done
- disp_val  out  2W  value to display mux
- disp_mode  out  2  0 = entering A, 1 = entering B, 2 = result, 3 = error
- err  out  1  high while in ERR

## Operation

- States: ENT_A, ENT_B, START, WAIT, SHOW, ERR. Reset state is ENT_A.
- Input priority within one cycle: key_clear > key_enter > key_valid.
- key_clear in any state:
  - go to ENT_A;
  - zero a_buf and b_buf;
  - drop any pending divider result. A later div_done is ignored.
- Digit entry in ENT_A/ENT_B: buf <= {buf[W-5:0], key_code}. Past NDIG digits, the oldest digit is discarded.
- ENT_A + key_enter:
  - a_buf is frozen as A;
  - b_buf is cleared;
  - go to ENT_B.
  - An operand with zero digits entered is 0.
- ENT_B + key_enter:
  - if b_buf == 0, go to ERR. No div_start is issued.
  - otherwise go to START.
- START lasts one cycle: div_start = 1, then go to WAIT.
- div_a/div_b:
  - equal a_buf/b_buf at all times;
  - held stable from START until leaving WAIT.
- WAIT + div_done: latch div_quot/div_rem into q_reg/r_reg, then go to SHOW.
- SHOW + key_valid: go to ENT_A with a_buf = {0, key_code} and b_buf = 0.
- SHOW + key_enter: ignored.
- ERR: only key_clear or a key_valid exits. Same behaviour as in SHOW.
- key_enter/key_valid in START or WAIT are ignored.
- disp_val by state:
  - ENT_A: {W'0, a_buf}
  - ENT_B: {a_buf, b_buf}
  - START/WAIT: {a_buf, b_buf}
  - SHOW: {q_reg, r_reg}
  - ERR: all nibbles 0xE
- disp_mode by state:
  - START/WAIT: 1
  - other states as listed in the port description.

## Timing

- Reset values:
  - div_start = 0;
  - div_a = div_b = 0;
  - disp_val = 0;
  - disp_mode = 0;
  - err = 0;
  - a_buf = b_buf = q_reg = r_reg = 0.
- All outputs are registered or derived from registered state only. No combinational path from key_* or div_done to any output.
- Latency:
  - key_enter in ENT_B at cycle n gives div_start high in cycle n+1 only.
  - div_done at cycle m gives disp_mode = 2 and result on disp_val at cycle m+1.
- div_done is only sampled in WAIT. A pulse coincident with div_start (START state) is ignored.
- key_clear in the same cycle as div_done in WAIT: clear wins and the result is discarded.
- A digit takes effect one cycle after its key_valid.

## Configuration

- DIVCTRL_TIMEOUT_EN defined:
  - a cycle counter runs in WAIT and resets on entry to WAIT;
  - if TIMEOUT cycles elapse without div_done, go to ERR;
  - a div_done arriving in the same cycle as expiry wins and goes to SHOW.
- Undefined: WAIT persists until div_done or key_clear. No counter logic is synthesized.

## Test plan

- Normal division: digits 7,F, enter, digits 0,5, enter; divider model answers 0x19/0x02 after 10 cycles.
  - Exactly one div_start pulse with div_a = 0x7F, div_b = 0x05.
  - disp_val = 0x1902 and disp_mode = 2 after div_done.
- Divide by zero: enter A = 0x12, then enter with no B digits.
  - No div_start; err = 1; disp_val = 0xEEEE; disp_mode = 3.
- Digit overflow: digits 1,2,3 in ENT_A.
  - a_buf = 0x23; disp_val = 0x0023.
- Clear during WAIT: key_clear 3 cycles after div_start, then divider asserts div_done.
  - State ENT_A; disp_val = 0; the late div_done causes no change.
- Priority: key_clear, key_enter and key_valid all asserted together in ENT_B with b_buf = 0x05.
  - Goes to ENT_A with zeroed buffers; no div_start.
- With DIVCTRL_TIMEOUT_EN and TIMEOUT = 16, divider never responds.
  - ERR entered exactly 16 cycles after entering WAIT; err = 1.
  - Without the macro, still in WAIT after 1000 cycles.

Source files
------------

// File: rtl/divisor_ctrl.sv
// Keypad-driven divider sequencer: collects two hex operands, launches the divider, shows the result.
// Optional WAIT timeout is compiled in with `define DIVCTRL_TIMEOUT_EN.
module divisor_ctrl #(
    parameter int W       = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           key_valid,
    input  logic [3:0]     key_code,
    input  logic           key_enter,
    input  logic           key_clear,
    output logic           div_start,
    output logic [W-1:0]   div_a,
    output logic [W-1:0]   div_b,
    input  logic           div_done,
    input  logic [W-1:0]   div_quot,
    input  logic [W-1:0]   div_rem,
    output logic [2*W-1:0] disp_val,
    output logic [1:0]     disp_mode,
    output logic           err
);
    localparam int NDIG = W / 4;

    if ((W % 4) != 0 || W < 4 || TIMEOUT < 1) begin : g_bad_param
        $error("divisor_ctrl: W must be a non-zero multiple of 4 and TIMEOUT >= 1");
    end

    typedef enum logic [2:0] {
        ST_ENT_A,
        ST_ENT_B,
        ST_START,
        ST_WAIT,
        ST_SHOW,
        ST_ERR
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   a_buf_q, a_buf_d;
    logic [W-1:0]   b_buf_q, b_buf_d;
    logic [W-1:0]   q_reg_q, q_reg_d;
    logic [W-1:0]   r_reg_q, r_reg_d;
    logic           tmo_expired;

`ifdef DIVCTRL_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] tmo_q, tmo_d;

    assign tmo_expired = (tmo_q == '0);

    // Loaded on the way into WAIT so that WAIT lasts exactly TIMEOUT cycles.
    always_comb begin
        tmo_d = tmo_q;
        if (state_d == ST_WAIT && state_q != ST_WAIT) begin
            tmo_d = CW'(TIMEOUT - 1);
        end else if (state_q == ST_WAIT && tmo_q != '0) begin
            tmo_d = tmo_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_expired = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        a_buf_d = a_buf_q;
        b_buf_d = b_buf_q;
        q_reg_d = q_reg_q;
        r_reg_d = r_reg_q;
        if (key_clear) begin
            state_d = ST_ENT_A;
            a_buf_d = '0;
            b_buf_d = '0;
        end else begin
            case (state_q)
                ST_ENT_A: begin
                    if (key_enter) begin
                        b_buf_d = '0;
                        state_d = ST_ENT_B;
                    end else if (key_valid) begin
                        a_buf_d = (a_buf_q << 4) | W'(key_code);
                    end
                end
                ST_ENT_B: begin
                    if (key_enter) begin
                        state_d = (b_buf_q == '0) ? ST_ERR : ST_START;
                    end else if (key_valid) begin
                        b_buf_d = (b_buf_q << 4) | W'(key_code);
                    end
                end
                ST_START: state_d = ST_WAIT;
                ST_WAIT: begin
                    // A completion in the expiry cycle still counts as a result.
                    if (div_done) begin
                        q_reg_d = div_quot;
                        r_reg_d = div_rem;
                        state_d = ST_SHOW;
                    end else if (tmo_expired) begin
                        state_d = ST_ERR;
                    end
                end
                ST_SHOW, ST_ERR: begin
                    // A new digit starts the next operand A; enter has priority and is a no-op here.
                    if (!key_enter && key_valid) begin
                        a_buf_d = W'(key_code);
                        b_buf_d = '0;
                        state_d = ST_ENT_A;
                    end
                end
                default: state_d = ST_ENT_A;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ENT_A;
            a_buf_q <= '0;
            b_buf_q <= '0;
            q_reg_q <= '0;
            r_reg_q <= '0;
        end else begin
            state_q <= state_d;
            a_buf_q <= a_buf_d;
            b_buf_q <= b_buf_d;
            q_reg_q <= q_reg_d;
            r_reg_q <= r_reg_d;
        end
    end

    assign div_start = (state_q == ST_START);
    assign div_a     = a_buf_q;
    assign div_b     = b_buf_q;
    assign err       = (state_q == ST_ERR);

    always_comb begin
        disp_val  = {a_buf_q, b_buf_q};
        disp_mode = 2'd1;
        case (state_q)
            ST_ENT_A: begin
                disp_val  = {{W{1'b0}}, a_buf_q};
                disp_mode = 2'd0;
            end
            ST_SHOW: begin
                disp_val  = {q_reg_q, r_reg_q};
                disp_mode = 2'd2;
            end
            ST_ERR: begin
                disp_val  = {(2 * NDIG){4'hE}};
                disp_mode = 2'd3;
            end
            default: begin
                disp_val  = {a_buf_q, b_buf_q};
                disp_mode = 2'd1;
            end
        endcase
    end
endmodule

// File: tb/tb_divisor_ctrl.sv
// Directed bench for divisor_ctrl with a behavioural divider that answers 10 cycles after div_start.
module tb_divisor_ctrl;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           key_valid;
    logic [3:0]     key_code;
    logic           key_enter;
    logic           key_clear;
    logic           div_start;
    logic [W-1:0]   div_a;
    logic [W-1:0]   div_b;
    logic           div_done;
    logic [W-1:0]   div_quot;
    logic [W-1:0]   div_rem;
    logic [2*W-1:0] disp_val;
    logic [1:0]     disp_mode;
    logic           err;

    always #5 clk = ~clk;

    divisor_ctrl #(.W(W), .TIMEOUT(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_enter (key_enter),
        .key_clear (key_clear),
        .div_start (div_start),
        .div_a     (div_a),
        .div_b     (div_b),
        .div_done  (div_done),
        .div_quot  (div_quot),
        .div_rem   (div_rem),
        .disp_val  (disp_val),
        .disp_mode (disp_mode),
        .err       (err)
    );

    int n_checks  = 0;
    int n_err     = 0;
    int start_cnt = 0;
    int done_cnt  = 0;
    int pend      = -1;
    logic model_en = 1'b1;
    logic [W-1:0] mq, mr;

    // Divider model: pulses div_done 10 cycles after div_start, even if the controller was cleared.
    initial begin
        div_done = 1'b0;
        div_quot = '0;
        div_rem  = '0;
        forever begin
            @(negedge clk);
            div_done = 1'b0;
            if (div_start) begin
                start_cnt++;
                if (model_en) begin
                    pend = 10;
                    mq   = (div_b != 0) ? div_a / div_b : '1;
                    mr   = (div_b != 0) ? div_a % div_b : div_a;
                end
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    div_done = 1'b1;
                    div_quot = mq;
                    div_rem  = mr;
                    done_cnt++;
                    pend     = -1;
                end
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic press_digit(input logic [3:0] d);
        key_valid = 1'b1;
        key_code  = d;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic press_enter();
        key_enter = 1'b1;
        @(negedge clk);
        key_enter = 1'b0;
    endtask

    task automatic press_clear();
        key_clear = 1'b1;
        @(negedge clk);
        key_clear = 1'b0;
    endtask

    task automatic wait_done(input int base, input string tag);
        for (int i = 0; i < 40 && done_cnt == base; i++) begin
            @(negedge clk);
            #1;
        end
        check_eq(tag, 32'(done_cnt != base), 32'd1);
    endtask

    int sc;
    int base;

    initial begin
        rst       = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'h0;
        key_enter = 1'b0;
        key_clear = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_start", 32'(div_start), 32'd0);
        check_eq("rst_a", 32'(div_a), 32'd0);
        check_eq("rst_b", 32'(div_b), 32'd0);
        check_eq("rst_disp", 32'(disp_val), 32'd0);
        check_eq("rst_mode", 32'(disp_mode), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Normal division 0x7F / 0x05
        press_digit(4'h7);
        press_digit(4'hF);
        check_eq("enta_disp", 32'(disp_val), 32'h007F);
        check_eq("enta_mode", 32'(disp_mode), 32'd0);
        press_enter();
        check_eq("entb_disp0", 32'(disp_val), 32'h7F00);
        check_eq("entb_mode", 32'(disp_mode), 32'd1);
        press_digit(4'h0);
        press_digit(4'h5);
        check_eq("entb_disp", 32'(disp_val), 32'h7F05);
        press_enter();
        check_eq("start_pulse", 32'(div_start), 32'd1);
        check_eq("start_a", 32'(div_a), 32'h7F);
        check_eq("start_b", 32'(div_b), 32'h05);
        check_eq("start_mode", 32'(disp_mode), 32'd1);
        base = done_cnt;
        @(negedge clk);
        check_eq("start_single", 32'(div_start), 32'd0);
        check_eq("wait_a_held", 32'(div_a), 32'h7F);
        wait_done(base, "norm_done_seen");
        check_eq("done_cycle_mode", 32'(disp_mode), 32'd1);
        @(negedge clk);
        check_eq("show_mode", 32'(disp_mode), 32'd2);
        check_eq("show_disp", 32'(disp_val), 32'h1902);
        check_eq("start_count", 32'(start_cnt), 32'd1);
        press_enter();
        check_eq("show_enter_ign", 32'(disp_mode), 32'd2);
        check_eq("show_enter_val", 32'(disp_val), 32'h1902);
        press_digit(4'h4);
        check_eq("show_digit_mode", 32'(disp_mode), 32'd0);
        check_eq("show_digit_disp", 32'(disp_val), 32'h0004);

        // Digit overflow
        press_clear();
        press_digit(4'h1);
        press_digit(4'h2);
        press_digit(4'h3);
        check_eq("ovf_disp", 32'(disp_val), 32'h0023);
        check_eq("ovf_a", 32'(div_a), 32'h23);

        // Divide by zero
        press_clear();
        press_digit(4'h1);
        press_digit(4'h2);
        press_enter();
        sc = start_cnt;
        press_enter();
        check_eq("dz_err", 32'(err), 32'd1);
        check_eq("dz_mode", 32'(disp_mode), 32'd3);
        check_eq("dz_disp", 32'(disp_val), 32'hEEEE);
        repeat (3) @(negedge clk);
        check_eq("dz_no_start", 32'(start_cnt), 32'(sc));
        check_eq("dz_err_hold", 32'(err), 32'd1);
        press_digit(4'h3);
        check_eq("dz_exit_mode", 32'(disp_mode), 32'd0);
        check_eq("dz_exit_disp", 32'(disp_val), 32'h0003);
        check_eq("dz_exit_err", 32'(err), 32'd0);

        // Clear during WAIT, late div_done ignored
        press_clear();
        press_digit(4'h1);
        press_digit(4'h0);
        press_enter();
        press_digit(4'h4);
        press_enter();
        check_eq("cw_start", 32'(div_start), 32'd1);
        base = done_cnt;
        repeat (2) @(negedge clk);
        press_clear();
        check_eq("cw_mode", 32'(disp_mode), 32'd0);
        check_eq("cw_disp", 32'(disp_val), 32'd0);
        wait_done(base, "cw_done_seen");
        @(negedge clk);
        check_eq("cw_late_mode", 32'(disp_mode), 32'd0);
        check_eq("cw_late_disp", 32'(disp_val), 32'd0);

        // Priority: clear + enter + digit together in ENT_B
        press_digit(4'h1);
        press_enter();
        press_digit(4'h0);
        press_digit(4'h5);
        check_eq("pri_pre_disp", 32'(disp_val), 32'h0105);
        sc = start_cnt;
        key_clear = 1'b1;
        key_enter = 1'b1;
        key_valid = 1'b1;
        key_code  = 4'h9;
        @(negedge clk);
        key_clear = 1'b0;
        key_enter = 1'b0;
        key_valid = 1'b0;
        check_eq("pri_mode", 32'(disp_mode), 32'd0);
        check_eq("pri_disp", 32'(disp_val), 32'd0);
        check_eq("pri_b", 32'(div_b), 32'd0);
        @(negedge clk);
        check_eq("pri_no_start", 32'(start_cnt), 32'(sc));

        // Divider never answers
        model_en = 1'b0;
        press_digit(4'h6);
        press_enter();
        press_digit(4'h3);
        press_enter();
        check_eq("to_start", 32'(div_start), 32'd1);
`ifdef DIVCTRL_TIMEOUT_EN
        repeat (16) @(negedge clk);
        check_eq("to_before_err", 32'(err), 32'd0);
        check_eq("to_before_mode", 32'(disp_mode), 32'd1);
        @(negedge clk);
        check_eq("to_err", 32'(err), 32'd1);
        check_eq("to_mode", 32'(disp_mode), 32'd3);
        check_eq("to_disp", 32'(disp_val), 32'hEEEE);
`else
        repeat (1000) @(negedge clk);
        check_eq("nto_mode", 32'(disp_mode), 32'd1);
        check_eq("nto_err", 32'(err), 32'd0);
        check_eq("nto_a", 32'(div_a), 32'h06);
`endif
        press_clear();
        check_eq("end_mode", 32'(disp_mode), 32'd0);
        model_en = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
